// File: rtl/calc_op_fsm.sv
// calc_op_fsm: operation controller for the TP3 keypad calculator.
// Collects two decimal operands from keypad strobes and latches an add or
// subtract operator. On "=" it computes the signed result and holds it for
// the display path.
// Optional feature macro: CALC_CHAIN_EN. When it is defined, an add/sub key
// continues from the previous result. Chaining works both from SHOW and from
// ENTER_B once B has at least one digit.
module calc_op_fsm #(
    parameter int DIGITS = 4,
    parameter int W      = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic [W-1:0] operand,
    output logic [W-1:0] result,
    output logic         result_neg,
    output logic         result_valid,
    output logic         overflow,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        CALC    = 2'b10,
        SHOW    = 2'b11
    } state_t;

    localparam int            CW         = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] DCOUNT_MAX = CW'(DIGITS);
    localparam logic [W+1:0]  MAX_MAG    = (W+2)'(10**DIGITS - 1);

    state_t              st;
    logic signed [W:0]   a_reg;
    logic [W-1:0]        b_reg;
    logic                op;
    logic [CW-1:0]       dcount;
    logic                chain_pend;
    logic                pend_op;

    logic                is_digit;
    logic                is_op;
    logic                is_eq;
    logic                is_clr;
    logic                key_op;
    logic                digit_room;
    logic signed [W:0]   a_next_digit;
    logic [W-1:0]        b_next_digit;
    logic signed [W+1:0] a_ext;
    logic signed [W+1:0] b_ext;
    logic signed [W+1:0] sum;
    logic [W+1:0]        mag;
    logic                sum_ovf;
    logic                chain_go;

    // Key decode; codes 14 and 15 match none of these and fall through as no-ops
    assign is_digit   = key_valid && (key_code <= 4'd9);
    assign is_op      = key_valid && ((key_code == 4'd10) || (key_code == 4'd11));
    assign is_eq      = key_valid && (key_code == 4'd12);
    assign is_clr     = key_valid && (key_code == 4'd13);
    assign key_op     = key_code[0];
    assign digit_room = (dcount < DCOUNT_MAX);

    // Decimal shift-in: x*10 + digit, done as (x<<3)+(x<<1) to avoid a multiplier
    assign a_next_digit = (a_reg <<< 3) + (a_reg <<< 1) + $signed({{(W-3){1'b0}}, key_code});
    assign b_next_digit = (b_reg << 3) + (b_reg << 1) + {{(W-4){1'b0}}, key_code};

    // Signed A +/- unsigned B, two bits wider than the magnitude so it never wraps
    assign a_ext   = {a_reg[W], a_reg};
    assign b_ext   = $signed({2'b00, b_reg});
    assign sum     = op ? (a_ext - b_ext) : (a_ext + b_ext);
    assign mag     = sum[W+1] ? $unsigned(-sum) : $unsigned(sum);
    assign sum_ovf = (mag > MAX_MAG);

    // A pending chain in CALC folds straight back into ENTER_B unless it overflowed
    assign chain_go = chain_pend && !sum_ovf;

    assign state = st;

    // Main controller: state, operand registers and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st           <= ENTER_A;
            a_reg        <= '0;
            b_reg        <= '0;
            op           <= 1'b0;
            dcount       <= '0;
            chain_pend   <= 1'b0;
            pend_op      <= 1'b0;
            operand      <= '0;
            result       <= '0;
            result_neg   <= 1'b0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else if (is_clr && (st != CALC)) begin
            st           <= ENTER_A;
            a_reg        <= '0;
            b_reg        <= '0;
            op           <= 1'b0;
            dcount       <= '0;
            chain_pend   <= 1'b0;
            pend_op      <= 1'b0;
            operand      <= '0;
            result       <= '0;
            result_neg   <= 1'b0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            case (st)
                ENTER_A: begin
                    if (is_digit && digit_room) begin
                        a_reg   <= a_next_digit;
                        dcount  <= dcount + 1'b1;
                        operand <= a_next_digit[W-1:0];
                    end else if (is_op) begin
                        op      <= key_op;
                        b_reg   <= '0;
                        dcount  <= '0;
                        operand <= '0;
                        st      <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit && digit_room) begin
                        b_reg   <= b_next_digit;
                        dcount  <= dcount + 1'b1;
                        operand <= b_next_digit;
                    end else if (is_op && (dcount == '0)) begin
                        op <= key_op;
                    end else if (is_op) begin
`ifdef CALC_CHAIN_EN
                        chain_pend <= 1'b1;
                        pend_op    <= key_op;
                        st         <= CALC;
`endif
                    end else if (is_eq) begin
                        st <= CALC;
                    end
                end
                CALC: begin
                    chain_pend <= 1'b0;
                    if (chain_go) begin
                        a_reg   <= sum[W:0];
                        op      <= pend_op;
                        b_reg   <= '0;
                        dcount  <= '0;
                        operand <= '0;
                        st      <= ENTER_B;
                    end else begin
                        result_valid <= 1'b1;
                        st           <= SHOW;
                        if (sum_ovf) begin
                            overflow   <= 1'b1;
                            result     <= '0;
                            result_neg <= 1'b0;
                        end else begin
                            overflow   <= 1'b0;
                            result     <= mag[W-1:0];
                            result_neg <= sum[W+1];
                        end
                    end
                end
                SHOW: begin
                    if (is_digit) begin
                        a_reg        <= $signed({{(W-3){1'b0}}, key_code});
                        dcount       <= CW'(1);
                        operand      <= {{(W-4){1'b0}}, key_code};
                        result_valid <= 1'b0;
                        overflow     <= 1'b0;
                        st           <= ENTER_A;
                    end else if (is_op && !overflow) begin
`ifdef CALC_CHAIN_EN
                        a_reg        <= result_neg ? -$signed({1'b0, result})
                                                   : $signed({1'b0, result});
                        op           <= key_op;
                        b_reg        <= '0;
                        dcount       <= '0;
                        operand      <= '0;
                        result_valid <= 1'b0;
                        overflow     <= 1'b0;
                        st           <= ENTER_B;
`endif
                    end
                end
                default: st <= ENTER_A;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_fsm.sv
// tb_calc_op_fsm: directed self-checking bench for calc_op_fsm.
// Keys are driven on the falling edge so the DUT samples them on the next
// rising edge. Outputs are checked on the following falling edge.
module tb_calc_op_fsm;

    localparam int DIGITS = 4;
    localparam int W      = 14;

    logic         clk;
    logic         reset;
    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] operand;
    logic [W-1:0] result;
    logic         result_neg;
    logic         result_valid;
    logic         overflow;
    logic [1:0]   state;

    int checks;
    int errors;

    calc_op_fsm #(.DIGITS(DIGITS), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .operand      (operand),
        .result       (result),
        .result_neg   (result_neg),
        .result_valid (result_valid),
        .overflow     (overflow),
        .state        (state)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one key for exactly one rising edge, then return on the next falling edge
    task automatic applyStimulus(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    // One idle cycle with no key strobe
    task automatic idleCycle();
        @(negedge clk);
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Directed scenario sequence
    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        checkOutput("rst_state",   32'(state),        32'd0);
        checkOutput("rst_operand", 32'(operand),      32'd0);
        checkOutput("rst_result",  32'(result),       32'd0);
        checkOutput("rst_neg",     32'(result_neg),   32'd0);
        checkOutput("rst_valid",   32'(result_valid), 32'd0);
        checkOutput("rst_ovf",     32'(overflow),     32'd0);

        // 12 + 34 = 46
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        checkOutput("add_opA",     32'(operand),      32'd12);
        applyStimulus(4'd10);
        checkOutput("add_stB",     32'(state),        32'd1);
        checkOutput("add_opB0",    32'(operand),      32'd0);
        applyStimulus(4'd3);
        applyStimulus(4'd4);
        checkOutput("add_opB",     32'(operand),      32'd34);
        applyStimulus(4'd12);
        checkOutput("add_calc",    32'(state),        32'd2);
        checkOutput("add_vld_n",   32'(result_valid), 32'd0);
        idleCycle();
        checkOutput("add_show",    32'(state),        32'd3);
        checkOutput("add_res",     32'(result),       32'd46);
        checkOutput("add_neg",     32'(result_neg),   32'd0);
        checkOutput("add_vld",     32'(result_valid), 32'd1);
        checkOutput("add_ovf",     32'(overflow),     32'd0);

        // A digit in SHOW starts a new A; 5 - 12 = -7, a key during CALC is dropped
        applyStimulus(4'd5);
        checkOutput("sub_opA",     32'(operand),      32'd5);
        checkOutput("sub_vld_n",   32'(result_valid), 32'd0);
        checkOutput("sub_stA",     32'(state),        32'd0);
        applyStimulus(4'd11);
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        applyStimulus(4'd12);
        applyStimulus(4'd7);
        checkOutput("sub_show",    32'(state),        32'd3);
        checkOutput("sub_res",     32'(result),       32'd7);
        checkOutput("sub_neg",     32'(result_neg),   32'd1);
        checkOutput("sub_ovf",     32'(overflow),     32'd0);

        // Digit limit and overflow: 9999 + 1
        applyStimulus(4'd13);
        repeat (4) applyStimulus(4'd9);
        checkOutput("lim_4dig",    32'(operand),      32'd9999);
        applyStimulus(4'd9);
        checkOutput("lim_5dig",    32'(operand),      32'd9999);
        applyStimulus(4'd10);
        applyStimulus(4'd1);
        applyStimulus(4'd12);
        idleCycle();
        checkOutput("ovf_flag",    32'(overflow),     32'd1);
        checkOutput("ovf_res",     32'(result),       32'd0);
        checkOutput("ovf_neg",     32'(result_neg),   32'd0);
        checkOutput("ovf_vld",     32'(result_valid), 32'd1);

        // Operator replaced before any B digit: 4 - 3 = 1, then clear from SHOW
        applyStimulus(4'd13);
        applyStimulus(4'd4);
        applyStimulus(4'd10);
        applyStimulus(4'd11);
        applyStimulus(4'd3);
        applyStimulus(4'd12);
        idleCycle();
        checkOutput("rep_res",     32'(result),       32'd1);
        checkOutput("rep_neg",     32'(result_neg),   32'd0);
        applyStimulus(4'd13);
        checkOutput("clr_state",   32'(state),        32'd0);
        checkOutput("clr_operand", 32'(operand),      32'd0);
        checkOutput("clr_result",  32'(result),       32'd0);
        checkOutput("clr_vld",     32'(result_valid), 32'd0);
        checkOutput("clr_ovf",     32'(overflow),     32'd0);

        // Second operator after B digits: chains when enabled, ignored otherwise
        applyStimulus(4'd2);
        applyStimulus(4'd10);
        applyStimulus(4'd3);
        applyStimulus(4'd10);
        idleCycle();
        checkOutput("chn_stB",     32'(state),        32'd1);
`ifdef CALC_CHAIN_EN
        checkOutput("chn_opB",     32'(operand),      32'd0);
`else
        checkOutput("chn_opB",     32'(operand),      32'd3);
`endif
        applyStimulus(4'd4);
        applyStimulus(4'd12);
        idleCycle();
`ifdef CALC_CHAIN_EN
        checkOutput("chn_res",     32'(result),       32'd9);
`else
        checkOutput("chn_res",     32'(result),       32'd36);
`endif
        checkOutput("chn_neg",     32'(result_neg),   32'd0);

        // Ignored codes, then asynchronous reset during CALC
        applyStimulus(4'd13);
        applyStimulus(4'd1);
        applyStimulus(4'd15);
        checkOutput("ign_code",    32'(operand),      32'd1);
        applyStimulus(4'd12);
        checkOutput("ign_eqA",     32'(state),        32'd0);
        applyStimulus(4'd10);
        applyStimulus(4'd1);
        applyStimulus(4'd12);
        checkOutput("ar_calc",     32'(state),        32'd2);
        reset = 1'b1;
        #1;
        checkOutput("ar_state",    32'(state),        32'd0);
        checkOutput("ar_operand",  32'(operand),      32'd0);
        checkOutput("ar_vld",      32'(result_valid), 32'd0);
        checkOutput("ar_result",   32'(result),       32'd0);
        @(negedge clk);
        reset = 1'b0;
        idleCycle();
        checkOutput("ar_vld_post", 32'(result_valid), 32'd0);
        checkOutput("ar_st_post",  32'(state),        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
